zap_decode_block_sequencer: RTL and testbench

- Sits between the fetch/thumb stage and the main decode stage.
- Expands each ARM block-transfer instruction (LDM/STM) into a sequence of single-register LDR/STR micro-ops, plus an optional base-writeback ADD/SUB.
- Issues one micro-op per unstalled cycle and holds fetch while it does so.
- All other instructions pass through unchanged with one cycle of latency.

---
 rtl/zap_decode_block_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_zap_decode_block_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zap_decode_block_sequencer.sv
// Expands ARM LDM/STM into single-register LDR/STR micro-ops plus an optional base writeback op.
// Every other instruction is registered through unchanged with one cycle of latency.
`timescale 1ns/1ps
module zap_decode_block_sequencer #(
    parameter int unsigned INSTR_W = 36
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [INSTR_W-1:0] i_instruction,
    input  logic               i_instruction_valid,
    input  logic               i_irq,
    input  logic               i_fiq,
    input  logic               i_clear_from_writeback,
    input  logic               i_data_stall,
    input  logic               i_clear_from_alu,
    input  logic               i_stall_from_shifter,
    input  logic               i_stall_from_issue,
    output logic [INSTR_W-1:0] o_instruction,
    output logic               o_instruction_valid,
    output logic               o_irq,
    output logic               o_fiq,
    output logic               o_stall_from_decode
);

    typedef enum logic {StIdle, StXfer} state_t;

    state_t      state;
    logic [3:0]  cond_r, rn_r;
    logic        p_r, u_r, l_r;
    logic [15:0] list_r, pend_r;
    logic [4:0]  n_r;
    logic        wb_r, rnld_r, pcld_r;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + {4'b0, v[i]};
        return c;
    endfunction

    logic is_block;
    assign is_block = (i_instruction[27:25] == 3'b100) && !i_instruction[22]
                      && (|i_instruction[15:0]);

    // Op source: the incoming instruction while idle, the captured fields while sequencing.
    logic [3:0]  s_cond, s_rn;
    logic        s_p, s_u, s_l, s_rn_in;
    logic [15:0] s_list, s_pend;
    logic [4:0]  s_n;
    logic        s_wb, s_rnld, s_pcld;

    always_comb begin
        s_cond  = cond_r;
        s_p     = p_r;
        s_u     = u_r;
        s_l     = l_r;
        s_rn    = rn_r;
        s_list  = list_r;
        s_n     = n_r;
        s_pend  = pend_r;
        s_wb    = wb_r;
        s_rnld  = rnld_r;
        s_pcld  = pcld_r;
        s_rn_in = 1'b0;
        if (state == StIdle) begin
            s_cond  = i_instruction[31:28];
            s_p     = i_instruction[24];
            s_u     = i_instruction[23];
            s_l     = i_instruction[20];
            s_rn    = i_instruction[19:16];
            s_list  = i_instruction[15:0];
            s_n     = popcount16(s_list);
            s_rn_in = s_list[s_rn];
            // Loads of Rn and PC are deferred to the end of the sequence.
            s_pend  = s_l ? (s_list & ~((16'h1 << s_rn) | 16'h8000)) : s_list;
            s_wb    = i_instruction[21] && !(s_l && s_rn_in);
            s_rnld  = s_l && s_rn_in;
            s_pcld  = s_l && s_list[15] && (s_rn != 4'hf);
        end
    end

    logic [3:0]         low, rd;
    logic               emit_wb, more;
    logic [15:0]        nx_pend;
    logic               nx_wb, nx_rnld, nx_pcld;
    logic [4:0]         rank;
    logic [9:0]         four_n, four_rank, start, off, mag;
    logic               neg;
    logic [INSTR_W-1:0] op;

    always_comb begin
        low = '0;
        for (int i = 15; i >= 0; i--) begin
            if (s_pend[i]) low = 4'(i);
        end
        nx_pend = s_pend;
        nx_wb   = s_wb;
        nx_rnld = s_rnld;
        nx_pcld = s_pcld;
        emit_wb = 1'b0;
        rd      = 4'hf;
        if (|s_pend) begin
            rd      = low;
            nx_pend = s_pend & (s_pend - 16'h1);
        end else if (s_wb) begin
            emit_wb = 1'b1;
            nx_wb   = 1'b0;
        end else if (s_rnld) begin
            rd      = s_rn;
            nx_rnld = 1'b0;
        end else begin
            nx_pcld = 1'b0;
        end
        more = (|nx_pend) || nx_wb || nx_rnld || nx_pcld;

        // Address is set by the register's rank in the full list, not by emission order.
        rank      = popcount16(s_list & ((16'h1 << rd) - 16'h1));
        four_n    = {3'b0, s_n, 2'b00};
        four_rank = {3'b0, rank, 2'b00};
        case ({s_p, s_u})
            2'b01:   start = 10'd0;
            2'b11:   start = 10'd4;
            2'b00:   start = 10'd4 - four_n;
            default: start = 10'd0 - four_n;
        endcase
        off = start + four_rank;
        neg = off[9];
        mag = neg ? (10'd0 - off) : off;

        if (emit_wb) begin
            op = {4'b0, s_cond, 3'b001, (s_u ? 4'b0100 : 4'b0010), 1'b0, s_rn, s_rn, 4'b0,
                  four_n[7:0]};
        end else begin
            op = {4'b0, s_cond, 3'b010, 1'b1, ~neg, 1'b0, 1'b0, s_l, s_rn, rd, 2'b00, mag};
        end
    end

    logic flush, hold;
    assign flush = i_reset || i_clear_from_writeback || (!i_data_stall && i_clear_from_alu);
    assign hold  = i_data_stall || i_stall_from_shifter || i_stall_from_issue;

    always_ff @(posedge i_clk) begin
        if (flush) begin
            state               <= StIdle;
            o_instruction       <= '0;
            o_instruction_valid <= 1'b0;
            o_irq               <= 1'b0;
            o_fiq               <= 1'b0;
            cond_r              <= '0;
            rn_r                <= '0;
            p_r                 <= 1'b0;
            u_r                 <= 1'b0;
            l_r                 <= 1'b0;
            list_r              <= '0;
            n_r                 <= '0;
            pend_r              <= '0;
            wb_r                <= 1'b0;
            rnld_r              <= 1'b0;
            pcld_r              <= 1'b0;
        end else if (!hold) begin
            if (state == StIdle && !(i_instruction_valid && is_block)) begin
                o_instruction       <= i_instruction;
                o_instruction_valid <= i_instruction_valid;
                o_irq               <= i_irq;
                o_fiq               <= i_fiq;
            end else begin
                o_instruction       <= op;
                o_instruction_valid <= 1'b1;
                o_irq               <= (state == StIdle) ? i_irq : 1'b0;
                o_fiq               <= (state == StIdle) ? i_fiq : 1'b0;
                if (state == StIdle) begin
                    cond_r <= s_cond;
                    rn_r   <= s_rn;
                    p_r    <= s_p;
                    u_r    <= s_u;
                    l_r    <= s_l;
                    list_r <= s_list;
                    n_r    <= s_n;
                end
                pend_r <= nx_pend;
                wb_r   <= nx_wb;
                rnld_r <= nx_rnld;
                pcld_r <= nx_pcld;
                state  <= more ? StXfer : StIdle;
            end
        end
    end

    assign o_stall_from_decode = (state != StIdle);

endmodule

// File: tb/tb_zap_decode_block_sequencer.sv
// Bench for zap_decode_block_sequencer: directed vectors, corner sequences and a random
// stream checked against a list-based model of the LDM/STM expansion.
`timescale 1ns/1ps
module tb_zap_decode_block_sequencer;

    logic        i_clk = 1'b0;
    logic        i_reset, i_instruction_valid, i_irq, i_fiq;
    logic        i_clear_from_writeback, i_data_stall, i_clear_from_alu;
    logic        i_stall_from_shifter, i_stall_from_issue;
    logic [35:0] i_instruction, o_instruction;
    logic        o_instruction_valid, o_irq, o_fiq, o_stall_from_decode;

    always #5 i_clk = ~i_clk;

    zap_decode_block_sequencer #(.INSTR_W(36)) dut (
        .i_clk                  (i_clk),
        .i_reset                (i_reset),
        .i_instruction          (i_instruction),
        .i_instruction_valid    (i_instruction_valid),
        .i_irq                  (i_irq),
        .i_fiq                  (i_fiq),
        .i_clear_from_writeback (i_clear_from_writeback),
        .i_data_stall           (i_data_stall),
        .i_clear_from_alu       (i_clear_from_alu),
        .i_stall_from_shifter   (i_stall_from_shifter),
        .i_stall_from_issue     (i_stall_from_issue),
        .o_instruction          (o_instruction),
        .o_instruction_valid    (o_instruction_valid),
        .o_irq                  (o_irq),
        .o_fiq                  (o_fiq),
        .o_stall_from_decode    (o_stall_from_decode)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [35:0] exp_q[$];

    typedef struct {
        logic [35:0]       ins;
        logic              irq;
        logic              fiq;
        int                n;
        logic [0:3][35:0]  ops;
    } vec_t;
    vec_t vecs[6];

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [35:0] ins, input logic v,
                              input logic irq, input logic fiq, input logic stall);
        chk({tag, " instr"}, o_instruction, ins);
        chk({tag, " valid"}, 36'(o_instruction_valid), 36'(v));
        chk({tag, " irq"}, 36'(o_irq), 36'(irq));
        chk({tag, " fiq"}, 36'(o_fiq), 36'(fiq));
        chk({tag, " stall"}, 36'(o_stall_from_decode), 36'(stall));
    endtask

    function automatic logic [35:0] mk_xfer(input logic [3:0] cond, input logic l,
                                            input logic [3:0] rn, input int r, input int a);
        logic [3:0]  rd;
        int          m;
        logic [11:0] m12;
        rd  = 4'(r);
        m   = (a < 0) ? -a : a;
        m12 = 12'(m);
        return {4'h0, cond, 3'b010, 1'b1, (a >= 0), 2'b00, l, rn, rd, m12};
    endfunction

    // Expected op list: pass-through yields the instruction itself.
    function automatic void model_ops(input logic [35:0] ins, input logic v, output bit blk);
        logic [15:0] lst;
        logic [3:0]  cond, rn;
        logic        p, u, w, l;
        int          n, start, k, rni;
        int          addr[16];
        lst  = ins[15:0];
        cond = ins[31:28];
        rn   = ins[19:16];
        rni  = int'(rn);
        p = ins[24]; u = ins[23]; w = ins[21]; l = ins[20];
        blk = v && (ins[27:25] == 3'b100) && !ins[22] && (lst != 16'h0);
        exp_q.delete();
        if (!blk) begin
            exp_q.push_back(ins);
            return;
        end
        n = $countones(lst);
        if (u) start = p ? 4 : 0;
        else   start = p ? -4 * n : -4 * (n - 1);
        k = 0;
        for (int r = 0; r < 16; r++) begin
            addr[r] = 0;
            if (lst[r]) begin
                addr[r] = start + 4 * k;
                k++;
            end
        end
        for (int r = 0; r < 16; r++) begin
            if (lst[r] && !(l && (r == rni || r == 15)))
                exp_q.push_back(mk_xfer(cond, l, rn, r, addr[r]));
        end
        if (w && !(l && lst[rni])) begin
            logic [7:0] amt;
            amt = 8'(4 * n);
            exp_q.push_back({4'h0, cond, 3'b001, (u ? 4'b0100 : 4'b0010), 1'b0, rn, rn, 4'h0,
                             amt});
        end
        if (l && lst[rni]) exp_q.push_back(mk_xfer(cond, l, rn, rni, addr[rni]));
        if (l && lst[15] && rni != 15) exp_q.push_back(mk_xfer(cond, l, rn, 15, addr[15]));
    endfunction

    task automatic run_instr(input logic [35:0] ins, input logic v, input logic irq,
                             input logic fiq, input bit holds);
        bit blk;
        int sz;
        model_ops(ins, v, blk);
        sz = exp_q.size();
        i_instruction = ins; i_instruction_valid = v; i_irq = irq; i_fiq = fiq;
        step();
        for (int k = 0; k < sz; k++) begin
            check_outs("rand", exp_q[k], (k > 0) ? 1'b1 : (blk ? 1'b1 : v),
                       (k == 0) ? irq : 1'b0, (k == 0) ? fiq : 1'b0, k < sz - 1);
            if (k < sz - 1) begin
                if (holds && $urandom_range(3) == 0) begin
                    int len;
                    len = int'($urandom_range(1, 2));
                    if ($urandom_range(1) == 0) i_stall_from_shifter = 1'b1;
                    else                        i_stall_from_issue = 1'b1;
                    for (int h = 0; h < len; h++) begin
                        step();
                        check_outs("rand hold", exp_q[k], 1'b1, (k == 0) ? irq : 1'b0,
                                   (k == 0) ? fiq : 1'b0, 1'b1);
                    end
                    i_stall_from_shifter = 1'b0;
                    i_stall_from_issue = 1'b0;
                end
                step();
            end
        end
    endtask

    function automatic logic [35:0] rand_instr();
        logic [35:0] x;
        x = {4'($urandom), $urandom};
        if ($urandom_range(3) != 0) begin
            x[27:25] = 3'b100;
            x[22]    = ($urandom_range(7) == 0);
            x[15:0]  = 16'($urandom & $urandom);
            if ($urandom_range(9) == 0) x[15:0] = 16'h0;
            if ($urandom_range(5) == 0) x[15:0] = 16'h1 << $urandom_range(15);
        end
        return x;
    endfunction

    initial begin
        vecs[0] = '{ins: 36'h0E2811001, irq: 1'b0, fiq: 1'b0, n: 1,
                    ops: {36'h0E2811001, 36'h0, 36'h0, 36'h0}};
        vecs[1] = '{ins: 36'h0E8B0000E, irq: 1'b1, fiq: 1'b0, n: 4,
                    ops: {36'h0E5901000, 36'h0E5902004, 36'h0E5903008, 36'h0E280000C}};
        vecs[2] = '{ins: 36'h0E92D4010, irq: 1'b0, fiq: 1'b1, n: 3,
                    ops: {36'h0E50D4008, 36'h0E50DE004, 36'h0E24DD008, 36'h0}};
        vecs[3] = '{ins: 36'h0E8B00003, irq: 1'b0, fiq: 1'b0, n: 2,
                    ops: {36'h0E5901004, 36'h0E5900000, 36'h0, 36'h0}};
        vecs[4] = '{ins: 36'h0E8B08002, irq: 1'b1, fiq: 1'b1, n: 3,
                    ops: {36'h0E5901000, 36'h0E2800008, 36'h0E590F004, 36'h0}};
        vecs[5] = '{ins: 36'h0E8920020, irq: 1'b0, fiq: 1'b0, n: 1,
                    ops: {36'h0E5925000, 36'h0, 36'h0, 36'h0}};

        i_reset = 1'b1; i_instruction = '0; i_instruction_valid = 1'b0;
        i_irq = 1'b0; i_fiq = 1'b0; i_clear_from_writeback = 1'b0; i_data_stall = 1'b0;
        i_clear_from_alu = 1'b0; i_stall_from_shifter = 1'b0; i_stall_from_issue = 1'b0;
        step();
        step();
        check_outs("reset", 36'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        i_reset = 1'b0;

        for (int t = 0; t < 6; t++) begin
            i_instruction = vecs[t].ins; i_instruction_valid = 1'b1;
            i_irq = vecs[t].irq; i_fiq = vecs[t].fiq;
            step();
            for (int k = 0; k < vecs[t].n; k++) begin
                check_outs($sformatf("vec%0d op%0d", t, k), vecs[t].ops[k], 1'b1,
                           (k == 0) ? vecs[t].irq : 1'b0, (k == 0) ? vecs[t].fiq : 1'b0,
                           k < vecs[t].n - 1);
                if (k < vecs[t].n - 1) step();
            end
        end
        i_irq = 1'b0; i_fiq = 1'b0;

        // Issue stall for two cycles after the second op.
        i_instruction = 36'h0E8B0000E; i_instruction_valid = 1'b1;
        step();
        step();
        i_stall_from_issue = 1'b1;
        step();
        check_outs("hold1", 36'h0E5902004, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        check_outs("hold2", 36'h0E5902004, 1'b1, 1'b0, 1'b0, 1'b1);
        i_stall_from_issue = 1'b0;
        step();
        check_outs("hold resume", 36'h0E5903008, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        check_outs("hold last", 36'h0E280000C, 1'b1, 1'b0, 1'b0, 1'b0);

        // ALU clear after the second op aborts the sequence.
        step();
        step();
        i_clear_from_alu = 1'b1; i_instruction_valid = 1'b0;
        step();
        check_outs("alu clear", 36'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        i_clear_from_alu = 1'b0;

        // Data stall outranks the ALU clear.
        i_instruction_valid = 1'b1;
        step();
        step();
        i_clear_from_alu = 1'b1; i_data_stall = 1'b1;
        step();
        check_outs("dstall>clr", 36'h0E5902004, 1'b1, 1'b0, 1'b0, 1'b1);
        i_clear_from_alu = 1'b0; i_data_stall = 1'b0;
        step();
        check_outs("dstall resume", 36'h0E5903008, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        check_outs("dstall last", 36'h0E280000C, 1'b1, 1'b0, 1'b0, 1'b0);

        // Writeback clear outranks the data stall.
        step();
        i_clear_from_writeback = 1'b1; i_data_stall = 1'b1; i_instruction_valid = 1'b0;
        step();
        check_outs("wb clear", 36'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        i_clear_from_writeback = 1'b0; i_data_stall = 1'b0;

        // Reset right after the first op.
        i_instruction_valid = 1'b1; i_irq = 1'b1;
        step();
        check_outs("rst first", 36'h0E5901000, 1'b1, 1'b1, 1'b0, 1'b1);
        i_reset = 1'b1; i_instruction_valid = 1'b0; i_irq = 1'b0;
        step();
        check_outs("mid reset", 36'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        i_reset = 1'b0;

        for (int t = 0; t < 300; t++) begin
            run_instr(rand_instr(), ($urandom_range(9) != 0), 1'($urandom), 1'($urandom), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
